// File: rtl/mp3_frame_tx.sv
// MPEG-1 Layer III frame transmitter: serialises a 32-bit header, an optional CRC word,
// and exactly enough payload bytes to fill the frame. Optional CRC insertion: MP3_TX_CRC_EN.
module mp3_frame_tx #(
  parameter logic [10:0] SYNC_WORD = 11'h7FF,
  parameter int          FS_W      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  bitrate_idx,
  input  logic [1:0]  samp_idx,
  input  logic        padding,
  input  logic        private_bit,
  input  logic [1:0]  mode,
  input  logic [1:0]  mode_ext,
  input  logic        copyright,
  input  logic        original,
  input  logic [1:0]  emphasis,
  input  logic        prot,
  input  logic [15:0] crc_in,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        frame_done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CRC,
    S_PAYLOAD,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       hdr_q, hdr_d;
  logic [15:0]       crc_q, crc_d;
  logic              crc_on_q, crc_on_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [FS_W-1:0]   rem_q, rem_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;

  logic              prot_eff;
  logic              crc_on;
  logic              req_bad;
  logic              load_en;
  logic [FS_W-1:0]   base_size;
  logic [7:0]        hdr_byte;

`ifdef MP3_TX_CRC_EN
  assign prot_eff = prot;
  assign crc_on   = !prot;
`else
  // Without CRC support the header always advertises "no CRC".
  assign prot_eff = 1'b1;
  assign crc_on   = 1'b0;
  logic unused_prot;
  assign unused_prot = prot;
`endif

  assign req_bad = (bitrate_idx == 4'd0) || (bitrate_idx == 4'd15) || (samp_idx != 2'b00);
  assign load_en = !m_valid_q || m_ready;

  // Frame lengths for 44.1 kHz, unpadded.
  always_comb begin
    base_size = '0;
    case (bitrate_idx)
      4'd1:    base_size = FS_W'(104);
      4'd2:    base_size = FS_W'(130);
      4'd3:    base_size = FS_W'(156);
      4'd4:    base_size = FS_W'(182);
      4'd5:    base_size = FS_W'(208);
      4'd6:    base_size = FS_W'(261);
      4'd7:    base_size = FS_W'(313);
      4'd8:    base_size = FS_W'(365);
      4'd9:    base_size = FS_W'(417);
      4'd10:   base_size = FS_W'(522);
      4'd11:   base_size = FS_W'(626);
      4'd12:   base_size = FS_W'(731);
      4'd13:   base_size = FS_W'(835);
      4'd14:   base_size = FS_W'(1044);
      default: base_size = '0;
    endcase
  end

  always_comb begin
    hdr_byte = '0;
    case (byte_cnt_q)
      2'd0:    hdr_byte = hdr_q[31:24];
      2'd1:    hdr_byte = hdr_q[23:16];
      2'd2:    hdr_byte = hdr_q[15:8];
      default: hdr_byte = hdr_q[7:0];
    endcase
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    crc_d        = crc_q;
    crc_on_d     = crc_on_q;
    byte_cnt_d   = byte_cnt_q;
    rem_d        = rem_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            hdr_d = {SYNC_WORD, 2'b11, 2'b01, prot_eff, bitrate_idx, samp_idx, padding,
                     private_bit, mode, mode_ext, copyright, original, emphasis};
            crc_d      = crc_in;
            crc_on_d   = crc_on;
            byte_cnt_d = '0;
            rem_d      = base_size + FS_W'(padding) - FS_W'(4) - (crc_on ? FS_W'(2) : '0);
            state_d    = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (load_en) begin
          m_data_d   = hdr_byte;
          m_valid_d  = 1'b1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            state_d    = crc_on_q ? S_CRC : S_PAYLOAD;
          end
        end
      end
      S_CRC: begin
        if (load_en) begin
          m_data_d   = byte_cnt_q[0] ? crc_q[7:0] : crc_q[15:8];
          m_valid_d  = 1'b1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q[0]) begin
            byte_cnt_d = '0;
            state_d    = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (s_valid && s_ready) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          rem_d     = rem_q - FS_W'(1);
          if (rem_q == FS_W'(1)) begin
            m_last_d = 1'b1;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (m_valid_q && m_ready && m_last_q) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hdr_q        <= '0;
      crc_q        <= '0;
      crc_on_q     <= 1'b0;
      byte_cnt_q   <= '0;
      rem_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      crc_q        <= crc_d;
      crc_on_q     <= crc_on_d;
      byte_cnt_q   <= byte_cnt_d;
      rem_q        <= rem_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign s_ready    = (state_q == S_PAYLOAD) && load_en && (rem_q != '0);
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mp3_frame_tx.sv
// Self-checking bench for mp3_frame_tx: randomized handshakes against a frame model built
// from bitrate arithmetic. Honors MP3_TX_CRC_EN when the bundle is compiled with it.
module tb_mp3_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  bitrate_idx;
  logic [1:0]  samp_idx;
  logic        padding;
  logic        private_bit;
  logic [1:0]  mode;
  logic [1:0]  mode_ext;
  logic        copyright;
  logic        original;
  logic [1:0]  emphasis;
  logic        prot;
  logic [15:0] crc_in;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        frame_done;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] pay[$];

  always #5 clk = ~clk;

  mp3_frame_tx dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .bitrate_idx(bitrate_idx), .samp_idx(samp_idx), .padding(padding),
    .private_bit(private_bit), .mode(mode), .mode_ext(mode_ext), .copyright(copyright),
    .original(original), .emphasis(emphasis), .prot(prot), .crc_in(crc_in),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .frame_done(frame_done),
    .err(err), .busy(busy)
  );

  // Frame length from the Layer III formula at 44.1 kHz: 144 * bitrate / fs (+ padding).
  function automatic int frame_size(input int br, input bit pad);
    int kbps[14] = '{32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320};
    return (144000 * kbps[br-1]) / 44100 + int'(pad);
  endfunction

  function automatic bit crc_active(input bit pr);
`ifdef MP3_TX_CRC_EN
    return !pr;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_frame(input logic [3:0] br, input logic pad, input logic pr,
                           input logic [15:0] crc, input logic [1:0] md, input logic [1:0] mx,
                           input logic cp, input logic orig, input logic [1:0] em,
                           input int rdy_pct, input int val_pct, input bit hold_req,
                           input bit lat_chk, input int abort_at);
    logic [7:0]  exp[$];
    logic [31:0] hdr;
    int          size, npay, oidx, pidx, cyc;
    bit          done_exp, last_now, prev_stall, finished, aborted;
    logic [7:0]  prev_data;

    hdr = {11'h7FF, 2'b11, 2'b01, crc_active(pr) ? 1'b0 : 1'b1, br, 2'b00, pad, 1'b0,
           md, mx, cp, orig, em};
    exp = '{hdr[31:24], hdr[23:16], hdr[15:8], hdr[7:0]};
    if (crc_active(pr)) begin
      exp.push_back(crc[15:8]);
      exp.push_back(crc[7:0]);
    end
    size = frame_size(int'(br), pad);
    npay = size - exp.size();
    pay.delete();
    for (int i = 0; i < npay + 8; i++) pay.push_back(8'($urandom));
    for (int i = 0; i < npay; i++) exp.push_back(pay[i]);
    got.delete();

    @(negedge clk);
    bitrate_idx = br; samp_idx = 2'b00; padding = pad; private_bit = 1'b0; mode = md;
    mode_ext = mx; copyright = cp; original = orig; emphasis = em; prot = pr; crc_in = crc;
    req_valid = 1'b1; m_ready = 1'b0; s_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    // Scramble the request inputs so the frame must come from latched fields.
    req_valid = hold_req; bitrate_idx = 4'd15; samp_idx = 2'($urandom); padding = 1'($urandom);
    mode = 2'($urandom); prot = 1'($urandom); crc_in = 16'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept: got %b want 1", busy);
    end

    oidx = 0; pidx = 0; cyc = 0; done_exp = 0; prev_stall = 0; prev_data = '0;
    finished = 0; aborted = 0;
    while (!finished && !aborted && cyc < 20000) begin
      @(negedge clk);
      if (abort_at > 0 && oidx >= abort_at) begin
        rst = 1'b1; req_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL abort_reset: m_valid=%b busy=%b req_ready=%b s_ready=%b want 0 0 1 0",
                   m_valid, busy, req_ready, s_ready);
        end
        rst = 1'b0;
        aborted = 1;
      end else begin
        m_ready = ($urandom_range(99) < rdy_pct);
        s_valid = ($urandom_range(99) < val_pct);
        s_data  = (pidx < pay.size()) ? pay[pidx] : 8'h00;
        #1;
        checks++;
        if (frame_done !== done_exp) begin
          errors++; $display("FAIL frame_done: got %b want %b at out byte %0d", frame_done, done_exp, oidx);
        end
        if (done_exp) begin
          req_valid = 1'b0;
          checks++;
          if (busy !== 1'b0 || req_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_end_state: busy=%b req_ready=%b m_valid=%b want 0 1 0",
                     busy, req_ready, m_valid);
          end
          finished = 1;
        end else begin
          checks++;
          if (req_ready !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL busy_ignore: req_ready=%b err=%b want 0 0", req_ready, err);
          end
          if (lat_chk && cyc < 2) begin
            checks++;
            if (m_valid !== (cyc == 1)) begin
              errors++; $display("FAIL latency: cycle %0d m_valid=%b want %b", cyc, m_valid, cyc == 1);
            end
          end
          if (prev_stall) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
              errors++;
              $display("FAIL stall_hold: m_valid=%b m_data=%h want 1 %h", m_valid, m_data, prev_data);
            end
          end
          last_now = 0;
          if (m_valid && m_ready) begin
            checks++;
            if (oidx >= size || m_data !== exp[oidx] || m_last !== (oidx == size - 1)) begin
              errors++;
              $display("FAIL byte %0d: got data=%h last=%b want data=%h last=%b", oidx, m_data,
                       m_last, (oidx < size) ? exp[oidx] : 8'h00, oidx == size - 1);
            end
            got.push_back(m_data);
            if (oidx == size - 1) last_now = 1;
            oidx++;
          end
          if (s_valid && s_ready) pidx++;
          prev_stall = m_valid && !m_ready;
          prev_data  = m_data;
          done_exp   = last_now;
        end
      end
      cyc++;
    end

    req_valid = 1'b0;
    if (!finished && !aborted) begin
      errors++; $display("FAIL timeout: frame not finished, %0d of %0d bytes", oidx, size);
    end
    if (finished) begin
      checks++;
      if (oidx != size || pidx != npay) begin
        errors++;
        $display("FAIL frame_count: out=%0d payload_taken=%0d want %0d %0d", oidx, pidx, size, npay);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
    bitrate_idx = '0; samp_idx = '0; padding = 0; private_bit = 0; mode = '0; mode_ext = '0;
    copyright = 0; original = 0; emphasis = '0; prot = 1; crc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 0 || m_last !== 0 || m_data !== 8'h00 || frame_done !== 0 || err !== 0 ||
        busy !== 0 || s_ready !== 0 || req_ready !== 1) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b data=%h done=%b err=%b busy=%b s_ready=%b req_ready=%b",
               m_valid, m_last, m_data, frame_done, err, busy, s_ready, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] want[4] = '{8'hFF, 8'hFB, 8'h90, 8'h44};
    run_frame(4'd9, 1'b0, 1'b1, 16'h0000, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 100, 100, 0, 1, 0);
    checks++;
    if (got.size() != 417) begin
      errors++; $display("FAIL basic_len: got %0d want 417", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL basic_hdr%0d: got %h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_padding();
    run_frame(4'd9, 1'b1, 1'b1, 16'h0000, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 100, 100, 0, 0, 0);
    checks++;
    if (got.size() != 418 || got[2] !== 8'h92) begin
      errors++;
      $display("FAIL padding: len=%0d byte2=%h want 418 92", got.size(), got.size() > 2 ? got[2] : 8'h00);
    end
  endtask

  task automatic test_reject();
    logic [3:0] brs[4]   = '{4'd15, 4'd0, 4'd5, 4'd9};
    logic [1:0] samps[4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      bitrate_idx = brs[t]; samp_idx = samps[t]; prot = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reject%0d: err=%b busy=%b req_ready=%b want 1 0 1", t, err, busy, req_ready);
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || m_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++;
          $display("FAIL reject%0d_after: err=%b m_valid=%b req_ready=%b want 0 0 1", t, err, m_valid, req_ready);
        end
      end
    end
  endtask

  task automatic test_crc();
    run_frame(4'd1, 1'b0, 1'b0, 16'hA5C3, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 100, 100, 0, 0, 0);
    checks++;
    if (got.size() != 104 || got[0] !== 8'hFF || got[2] !== 8'h10 || got[3] !== 8'h44) begin
      errors++; $display("FAIL crc_frame: len=%0d want 104 with header FF xx 10 44", got.size());
    end
`ifdef MP3_TX_CRC_EN
    checks++;
    if (got.size() < 6 || got[1] !== 8'hFA || got[4] !== 8'hA5 || got[5] !== 8'hC3) begin
      errors++; $display("FAIL crc_bytes: byte1/4/5 wrong, want FA A5 C3");
    end
`else
    checks++;
    if (got.size() < 2 || got[1] !== 8'hFB) begin
      errors++; $display("FAIL crc_disabled: byte1 want FB");
    end
`endif
  endtask

  task automatic test_random_stall();
    for (int f = 0; f < 4; f++) begin
      run_frame(4'($urandom_range(14, 1)), 1'($urandom), 1'($urandom), 16'($urandom),
                2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                55, 65, 1, 0, 0);
    end
  endtask

  task automatic test_abort_restart();
    run_frame(4'd9, 1'b0, 1'b1, 16'h0000, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 100, 100, 0, 0, 50);
    run_frame(4'd3, 1'b0, 1'b1, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 100, 100, 0, 1, 0);
    checks++;
    if (got.size() != 156 || got[0] !== 8'hFF) begin
      errors++; $display("FAIL restart: len=%0d want 156 starting FF", got.size());
    end
  endtask

  task automatic test_back_to_back();
    run_frame(4'd1, 1'b1, 1'b1, 16'h0000, 2'b11, 2'b10, 1'b1, 1'b0, 2'b01, 100, 100, 0, 1, 0);
    run_frame(4'd14, 1'b1, 1'b1, 16'h0000, 2'b10, 2'b01, 1'b0, 1'b1, 2'b11, 100, 100, 0, 1, 0);
    checks++;
    if (got.size() != 1045) begin
      errors++; $display("FAIL max_frame: len=%0d want 1045", got.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_reject();
    test_crc();
    test_random_stall();
    test_abort_restart();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp3_frame_tx.md
Name: mp3_frame_tx

Overview:
Transmit-side counterpart of the MPEG-1 Layer III frame header parser. Accepts decoded header fields as one request and serialises the 32-bit frame header (plus optional CRC word) as a byte stream. It then passes through exactly enough upstream payload bytes to fill the frame length implied by bitrate and padding. Sits between the encoder's side-info/main-data packer and the byte sink (UART/SD/loopback into the parser).

Parameters:
SYNC_WORD, 11'h7FF, frame sync pattern placed in header bits [31:21]
FS_W, 11, width of frame-size and remaining-byte counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  header request valid
req_ready  out  1  high only in IDLE
bitrate_idx  in  4  header bits [15:12]
samp_idx  in  2  header bits [11:10]; only 2'b00 (44.1 kHz) legal
padding  in  1  header bit 9
private_bit  in  1  header bit 8
mode  in  2  header bits [7:6]
mode_ext  in  2  header bits [5:4]
copyright  in  1  header bit 3
original  in  1  header bit 2
emphasis  in  2  header bits [1:0]
prot  in  1  header bit 16 (0 = CRC follows)
crc_in  in  16  CRC word, used only when the CRC feature is on and prot=0
s_data  in  8  payload byte in
s_valid  in  1  payload valid
s_ready  out  1  payload ready
m_data  out  8  output byte
m_valid  out  1  output valid
m_ready  in  1  output ready
m_last  out  1  marks the final byte of the frame
frame_done  out  1  one-cycle pulse
err  out  1  one-cycle pulse on a rejected request
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: state IDLE; m_valid=0, m_last=0, m_data=0, frame_done=0, err=0, busy=0, s_ready=0, counters=0.
- Handshakes: transfer on valid&&ready. m_data, m_valid and m_last are registered. A new byte loads into the output register when (!m_valid || m_ready). m_valid holds and m_data stays stable while m_ready=0.
- IDLE, on req_valid (req_ready=1):
  - Latch all fields.
  - Build header = {SYNC_WORD, 2'b11, 2'b01, prot_eff, bitrate_idx, samp_idx, padding, private_bit, mode, mode_ext, copyright, original, emphasis}.
- Reject condition: bitrate_idx is 0 or 15, or samp_idx != 00.
  - On reject: err=1 for one cycle, stay in IDLE, emit nothing.
- Frame size lookup, idx 1..14: 104, 130, 156, 182, 208, 261, 313, 365, 417, 522, 626, 731, 835, 1044; +1 if padding=1.
- Payload count: remaining = frame_size - 4 - (crc_on ? 2 : 0), where crc_on = CRC feature compiled in && prot=0.
- Accept cycle: the cycle after acceptance, the state is HDR.
- HDR: load header bytes MSB-first (bits [31:24], [23:16], [15:8], [7:0]), one per output-register load. After byte 3 loads, go to CRC if crc_on, else PAYLOAD.
- CRC: load crc_in[15:8], then crc_in[7:0]. Then go to PAYLOAD.
- PAYLOAD:
  - s_ready = (!m_valid || m_ready) && remaining != 0, combinational.
  - Each s_valid&&s_ready copies s_data into the output register and decrements remaining.
  - The byte that takes remaining from 1 to 0 sets m_last=1. Then go to DRAIN.
- DRAIN: wait for m_valid&&m_ready on the m_last byte. Then clear m_valid/m_last, pulse frame_done for one cycle, and return to IDLE.
- Latency: the first header byte appears on m_data/m_valid 2 cycles after the request is accepted. With m_ready held high and payload always valid, the output is one byte per cycle with no bubbles.
- Payload starvation: s_valid low stalls PAYLOAD indefinitely; no timeout.
- Extra upstream bytes beyond the frame are not consumed (s_ready=0 outside PAYLOAD).
- req_valid during busy is ignored (req_ready=0).
- rst mid-frame aborts immediately to the reset state. A partial frame is left on the link; the downstream parser must also be reset.

Optional Feature:
MP3_TX_CRC_EN
- Defined: prot passes through to header bit 16. prot=0 inserts crc_in as two bytes after the header and reduces payload by 2.
- Undefined: prot_eff is forced to 1, crc_in is ignored, and no CRC bytes are emitted.

Test Plan:
- bitrate_idx=9, samp=00, pad=0, prot=1, mode=01, mode_ext=00, copyright=0, original=1, emph=00; m_ready=1, payload always valid -> bytes FF FB 90 44, then 413 payload bytes; m_last on byte 417; frame_done one cycle after.
- Same request with pad=1 -> byte2=0x92; 414 payload bytes; 418 bytes total.
- bitrate_idx=15, or samp_idx=01 -> err pulse, no m_valid, req_ready stays 1.
- MP3_TX_CRC_EN defined, prot=0, crc_in=16'hA5C3, bitrate_idx=1 -> FF FA 10 44 A5 C3, then 98 payload bytes (104 total).
- m_ready toggled randomly, s_valid gapped -> byte order unchanged, m_data stable while stalled, exactly frame_size bytes out.
- rst asserted in PAYLOAD at byte 50 -> next cycle m_valid=0, busy=0, req_ready=1; a new request produces a clean frame starting FF.
